// File: rtl/jam_gen.sv
// Exhaustive job-assignment engine: loads an N x N cost table from a synchronous ROM,
// walks every worker->job permutation in lexicographic order and reports the min/max total and its multiplicity.
module jam_gen #(
  parameter int unsigned N   = 8,
  parameter int unsigned CW  = 7,
  parameter int unsigned MCW = 16,
  localparam int unsigned IW = (N > 2) ? $clog2(N) : 1,
  localparam int unsigned SW = CW + $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Start,
  input  logic           Mode,
  output logic [IW-1:0]  W,
  output logic [IW-1:0]  J,
  input  logic [CW-1:0]  Cost,
  output logic [SW-1:0]  BestCost,
  output logic [MCW-1:0] MatchCount,
  output logic           Valid,
  output logic           Busy
);

  typedef enum logic [1:0] {IDLE, FETCH, PERM, DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state;
  logic          mode_q;
  logic          addr_on;
  logic          cap_on;
  logic [IW-1:0] cap_w;
  logic [IW-1:0] cap_j;
  logic          first;
  logic [CW-1:0] tbl  [N][N];
  logic [IW-1:0] perm [N];

  logic [IW-1:0] perm_nxt_c [N];
  logic [IW-1:0] swp_c      [N];
  logic [IW-1:0] piv_c;
  logic [IW-1:0] sj_c;
  logic          has_piv_c;
  logic [SW-1:0] sum_c;
  logic          better_c;

  // Lexicographic successor: rightmost ascent is the pivot, swap with rightmost larger element, reverse the tail.
  always_comb begin
    piv_c     = '0;
    has_piv_c = 1'b0;
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (perm[i] < perm[i+1]) begin
        piv_c     = IW'(i);
        has_piv_c = 1'b1;
      end
    end
    sj_c = piv_c;
    for (int j = 0; j < int'(N); j++) begin
      if (IW'(j) > piv_c && perm[j] > perm[piv_c]) sj_c = IW'(j);
    end
    swp_c        = perm;
    swp_c[piv_c] = perm[sj_c];
    swp_c[sj_c]  = perm[piv_c];
    perm_nxt_c   = swp_c;
    for (int k = 0; k < int'(N); k++) begin
      if (IW'(k) > piv_c) perm_nxt_c[k] = swp_c[IW'(int'(N) + int'(piv_c) - k)];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N); i++) sum_c = sum_c + SW'(tbl[i][perm[i]]);
    better_c = mode_q ? (sum_c > BestCost) : (sum_c < BestCost);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      addr_on    <= 1'b0;
      cap_on     <= 1'b0;
      cap_w      <= '0;
      cap_j      <= '0;
      first      <= 1'b0;
      W          <= '0;
      J          <= '0;
      BestCost   <= '0;
      MatchCount <= '0;
      Valid      <= 1'b0;
      Busy       <= 1'b0;
      for (int i = 0; i < int'(N); i++) perm[i] <= IW'(i);
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state      <= FETCH;
            mode_q     <= Mode;
            addr_on    <= 1'b1;
            cap_on     <= 1'b0;
            W          <= '0;
            J          <= '0;
            BestCost   <= '0;
            MatchCount <= '0;
            Valid      <= 1'b0;
            Busy       <= 1'b1;
          end
        end
        FETCH: begin
          // Two-stage pipe: address out, ROM registers it, data captured one edge later.
          cap_on <= addr_on;
          cap_w  <= W;
          cap_j  <= J;
          if (addr_on) begin
            if (J == LAST_IDX) begin
              J <= '0;
              if (W == LAST_IDX) begin
                W       <= '0;
                addr_on <= 1'b0;
              end else begin
                W <= W + IW'(1);
              end
            end else begin
              J <= J + IW'(1);
            end
          end
          if (cap_on) begin
            tbl[cap_w][cap_j] <= Cost;
            if (cap_w == LAST_IDX && cap_j == LAST_IDX) begin
              state <= PERM;
              first <= 1'b1;
              for (int i = 0; i < int'(N); i++) perm[i] <= IW'(i);
            end
          end
        end
        PERM: begin
          if (first || better_c) begin
            BestCost   <= sum_c;
            MatchCount <= MCW'(1);
          end else if (sum_c == BestCost && MatchCount != '1) begin
            MatchCount <= MatchCount + MCW'(1);
          end
          first <= 1'b0;
          perm  <= perm_nxt_c;
          if (!has_piv_c) begin
            state <= DONE;
            Valid <= 1'b1;
            Busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_gen.sv
// Self-checking bench for jam_gen: N=3 directed/random runs, N=8 full-size run and N=4 saturation,
// all checked per cycle against a brute-force tuple-enumeration reference.
module tb_jam_gen;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic       RST, rst3;
  logic       start3, mode3, start8, mode8, start4, mode4;
  logic [1:0] w3, j3, w4, j4;
  logic [2:0] w8, j8;
  logic [6:0] cost3, cost8, cost4;
  logic [8:0] best3, best4;
  logic [9:0] best8;
  logic [15:0] mc3, mc8;
  logic [3:0] mc4;
  logic valid3, busy3, valid8, busy8, valid4, busy4;

  int rom3 [64];
  int rom8 [64];
  int rom4 [64];

  jam_gen #(.N(3)) dut3 (.CLK(CLK), .RST(rst3), .Start(start3), .Mode(mode3), .W(w3), .J(j3),
    .Cost(cost3), .BestCost(best3), .MatchCount(mc3), .Valid(valid3), .Busy(busy3));
  jam_gen dut8 (.CLK(CLK), .RST(RST), .Start(start8), .Mode(mode8), .W(w8), .J(j8),
    .Cost(cost8), .BestCost(best8), .MatchCount(mc8), .Valid(valid8), .Busy(busy8));
  jam_gen #(.N(4), .MCW(4)) dut4 (.CLK(CLK), .RST(RST), .Start(start4), .Mode(mode4), .W(w4), .J(j4),
    .Cost(cost4), .BestCost(best4), .MatchCount(mc4), .Valid(valid4), .Busy(busy4));

  // Synchronous cost ROMs: data appears one edge after the address is sampled.
  always @(posedge CLK) begin
    cost3 <= 7'(rom3[int'(w3) * 3 + int'(j3)]);
    cost8 <= 7'(rom8[int'(w8) * 8 + int'(j8)]);
    cost4 <= 7'(rom4[int'(w4) * 4 + int'(j4)]);
  end

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  // Reference: enumerate every n-digit base-n tuple, keep the ones with distinct digits.
  function automatic void model(input int n, input int mcw, input int tbl[64], input bit mode,
                                output int best, output int cnt);
    int total = 1;
    bit seen = 0;
    for (int i = 0; i < n; i++) total *= n;
    best = 0;
    cnt  = 0;
    for (int code = 0; code < total; code++) begin
      int x = code;
      int mask = 0;
      int s = 0;
      bit ok = 1;
      for (int i = 0; i < n; i++) begin
        int d = x % n;
        x = x / n;
        if (mask[d]) ok = 0;
        mask[d] = 1'b1;
        s += tbl[i * n + d];
      end
      if (ok) begin
        if (!seen || (mode ? s > best : s < best)) begin
          best = s;
          cnt  = 1;
          seen = 1;
        end else if (s == best) begin
          cnt++;
        end
      end
    end
    if (cnt > (1 << mcw) - 1) cnt = (1 << mcw) - 1;
  endfunction

  // One N=3 run, checked every cycle; optional Start pulses during FETCH and PERM.
  task automatic run3(input bit m, input bit disturb);
    int eb, ec;
    model(3, 16, rom3, m, eb, ec);
    @(negedge CLK);
    start3 = 1'b1;
    mode3  = m;
    @(negedge CLK);
    for (int c = 0; c < 16; c++) begin
      start3 = disturb && (c == 3 || c == 12);
      mode3  = start3 ? ~m : m;
      chk("busy3", c, int'(busy3), 1);
      chk("valid3", c, int'(valid3), 0);
      if (c < 9) begin
        chk("w3", c, int'(w3), c / 3);
        chk("j3", c, int'(j3), c % 3);
      end
      @(negedge CLK);
    end
    start3 = 1'b0;
    chk("valid3_end", 16, int'(valid3), 1);
    chk("busy3_end", 16, int'(busy3), 0);
    chk("w3_done", 16, int'(w3), 0);
    chk("best3", 16, int'(best3), eb);
    chk("mc3", 16, int'(mc3), ec);
  endtask

  task automatic run4(input bit m, input int lit_best, input int lit_cnt);
    int eb, ec;
    model(4, 4, rom4, m, eb, ec);
    if (lit_best >= 0) begin
      chk("model4_best", 0, eb, lit_best);
      chk("model4_cnt", 0, ec, lit_cnt);
    end
    @(negedge CLK);
    start4 = 1'b1;
    mode4  = m;
    @(negedge CLK);
    start4 = 1'b0;
    for (int c = 0; c < 41; c++) begin
      chk("busy4", c, int'(busy4), 1);
      chk("valid4", c, int'(valid4), 0);
      if (c < 16) begin
        chk("w4", c, int'(w4), c / 4);
        chk("j4", c, int'(j4), c % 4);
      end
      @(negedge CLK);
    end
    chk("valid4_end", 41, int'(valid4), 1);
    chk("busy4_end", 41, int'(busy4), 0);
    chk("best4", 41, int'(best4), eb);
    chk("mc4", 41, int'(mc4), ec);
  endtask

  task automatic chk_zero3(input int idx);
    chk("rst_w3", idx, int'(w3), 0);
    chk("rst_j3", idx, int'(j3), 0);
    chk("rst_best3", idx, int'(best3), 0);
    chk("rst_mc3", idx, int'(mc3), 0);
    chk("rst_valid3", idx, int'(valid3), 0);
    chk("rst_busy3", idx, int'(busy3), 0);
  endtask

  initial begin
    int eb, ec;
    RST = 1'b1; rst3 = 1'b1;
    start3 = 0; mode3 = 0; start8 = 0; mode8 = 0; start4 = 0; mode4 = 0;
    for (int i = 0; i < 64; i++) begin
      rom8[i] = 127;
      rom4[i] = 5;
      rom3[i] = 0;
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) rom3[i * 3 + j] = (i + 1) * (j + 1);
    repeat (3) @(negedge CLK);
    chk_zero3(0);
    chk("rst_valid8", 0, int'(valid8), 0);
    chk("rst_busy8", 0, int'(busy8), 0);
    chk("rst_best4", 0, int'(best4), 0);
    RST = 1'b0; rst3 = 1'b0;

    model(3, 16, rom3, 1'b0, eb, ec);
    chk("model3_min_best", 0, eb, 10);
    chk("model3_min_cnt", 0, ec, 1);
    model(3, 16, rom3, 1'b1, eb, ec);
    chk("model3_max_best", 0, eb, 14);
    chk("model3_max_cnt", 0, ec, 1);

    fork
      begin : n3_branch
        run3(1'b0, 1'b0);
        chk("lit_best3_min", 0, int'(best3), 10);
        run3(1'b1, 1'b0);
        chk("lit_best3_max", 0, int'(best3), 14);
        run3(1'b0, 1'b0);
        chk("lit_best3_restart", 0, int'(best3), 10);
        run3(1'b0, 1'b1);
        chk("lit_best3_disturbed", 0, int'(best3), 10);
        // Abandon a run mid-PERM and rerun.
        @(negedge CLK);
        start3 = 1'b1; mode3 = 1'b1;
        @(negedge CLK);
        start3 = 1'b0;
        repeat (12) @(negedge CLK);
        rst3 = 1'b1;
        @(negedge CLK);
        chk_zero3(1);
        @(negedge CLK);
        chk_zero3(2);
        rst3 = 1'b0;
        run3(1'b0, 1'b0);
        chk("lit_best3_after_rst", 0, int'(best3), 10);
        chk("lit_mc3_after_rst", 0, int'(mc3), 1);
        for (int r = 0; r < 40; r++) begin
          int hi = (r % 2 == 0) ? 127 : 2;
          for (int i = 0; i < 9; i++) rom3[i] = int'($urandom_range(hi, 0));
          run3(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
      end
      begin : n8_branch
        @(negedge CLK);
        start8 = 1'b1; mode8 = 1'b0;
        @(negedge CLK);
        start8 = 1'b0;
        for (int c = 0; c < 40385; c++) begin
          chk("busy8", c, int'(busy8), 1);
          chk("valid8", c, int'(valid8), 0);
          if (c < 64) begin
            chk("w8", c, int'(w8), c / 8);
            chk("j8", c, int'(j8), c % 8);
          end
          @(negedge CLK);
        end
        chk("valid8_end", 40385, int'(valid8), 1);
        chk("busy8_end", 40385, int'(busy8), 0);
        chk("best8", 40385, int'(best8), 1016);
        chk("mc8", 40385, int'(mc8), 40320);
      end
      begin : n4_branch
        run4(1'b0, 20, 15);
        chk("lit_best4", 0, int'(best4), 20);
        chk("lit_mc4", 0, int'(mc4), 15);
        for (int r = 0; r < 6; r++) begin
          for (int i = 0; i < 16; i++) rom4[i] = int'($urandom_range(1, 0));
          run4(1'($urandom_range(1, 0)), -1, 0);
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jam_gen.md
# jam_gen

Parametrised job-assignment engine: fetches an N×N cost table from an external synchronous cost ROM and exhaustively enumerates all N! worker→job permutations. It reports the best total cost, minimum or maximum as selected per run, and how many assignments reach it. It is the next generation of the fixed 8×8 JAM block, with the same cost-ROM addressing and result-port style, plus generic size, a start handshake, a min/max mode and a saturating match counter.

## Interface
- N, 8: workers = jobs; legal range 2..8
- CW, 7: cost word width
- MCW, 16: MatchCount width; 16 holds 8! = 40320
- Derived: IW = max(1, clog2(N)) index width; SW = CW + clog2(N) sum width (10 at defaults)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- Start  in  1  run request; sampled only in IDLE or DONE
- Mode  in  1  0 = minimise, 1 = maximise; latched with Start
- W  out  IW  worker index (ROM row)
- J  out  IW  job index (ROM column)
- Cost  in  CW  ROM data for the W/J sampled by the ROM one edge earlier
- BestCost  out  SW  optimal total cost
- MatchCount  out  MCW  number of permutations equal to BestCost, saturating
- Valid  out  1  results final
- Busy  out  1  high in FETCH and PERM

## Operation
- States: IDLE, FETCH, PERM, DONE.
- Reset: state IDLE; W, J, BestCost, MatchCount, Valid and Busy all 0; permutation register = identity.
- IDLE or DONE with Start=1:
  - go to FETCH and latch Mode;
  - clear Valid, BestCost and MatchCount;
  - set the fetch counter k to 0.
- FETCH:
  - drive W = k / N and J = k % N (row-major), k = 0..N·N−1;
  - the ROM registers W/J on one edge; the block captures Cost into table[W][J] on the next edge;
  - after the last capture, go to PERM with the permutation register p = identity (0,1,…,N−1).
- PERM, on each edge:
  - sum = Σ table[i][p[i]], computed combinationally and zero-extended to SW;
  - on the first permutation: BestCost = sum, MatchCount = 1;
  - later permutations that improve (sum < BestCost when Mode=0, sum > BestCost when Mode=1): BestCost = sum, MatchCount = 1;
  - later permutations with sum == BestCost: MatchCount + 1, saturating at 2^MCW − 1;
  - advance p to its lexicographic successor in the same cycle (find pivot, swap, reverse suffix; one permutation per cycle);
  - the edge that evaluates the last permutation (N−1,…,0) also enters DONE.
- DONE: Valid = 1; BestCost and MatchCount hold until the next Start or RST.
- Start in FETCH or PERM: ignored.
- W and J are 0 outside FETCH.
- Cost: unsigned; the sum cannot overflow SW.

## Timing
- Start is sampled at edge s. Entry k is addressed in the cycle after edge s+k and captured at edge s+k+2.
- PERM is entered at edge s+N²+1.
- Permutations are evaluated at edges s+N²+2 through s+N²+1+N!.
- Valid rises after edge s+N²+1+N!: latency = N² + 1 + N! cycles (16 for N=3; 40385 for N=8).
- Busy is high from edge s until the edge that raises Valid.
- RST mid-run: abandon the run at that edge and return to reset values; a run started afterwards is unaffected.
- Start while in DONE: Valid drops the following cycle and a fresh run begins.

## Test plan
- N=3, table rows {1 2 3},{2 4 6},{3 6 9}, Mode=0 → BestCost=10, MatchCount=1; Valid exactly 16 cycles after the Start edge; Busy high for those 16 cycles.
- Same table, Mode=1 → BestCost=14, MatchCount=1; then Start again with Mode=0 from DONE → Valid drops for one run, then BestCost=10.
- N=8 (defaults), all costs 127 → BestCost=1016, MatchCount=40320; Valid after 40385 cycles; W/J sweep 0..7 row-major during FETCH.
- N=4, MCW=4, all costs 5 → BestCost=20, MatchCount=15 (saturated from 24).
- Assert RST midway through PERM, then Start with the N=3 table → all outputs 0 during reset; the second run returns BestCost=10, MatchCount=1 with normal latency.
- Start pulses during FETCH and PERM → no restart; result and latency identical to the undisturbed run.
